// File: rtl/mmu_lsu_req_hold.sv
// mmu_lsu_req_hold
//
// Purpose:
//   LSU-side front end of the MMU. Accepts a one-cycle load, store or cache-op
//   request from the pipeline and holds it level-stable on the MMU dcache-side
//   request port. The request stays there until the MMU completes it or faults,
//   or until the watchdog expires. Store data is lane-replicated with byte
//   enables. Load data is lane-extracted and zero- or sign-extended. Only one
//   request can be outstanding, and req_ready_o acts as the pipeline stall.
//
// Parameters:
//   TIMEOUT_CYCLES  Number of BUSY cycles before the request is aborted with
//                   resp_bus_err_o. A value of 0 disables the watchdog.
//
// Configuration macro:
//   MMU_LSU_MISALIGN_CHECK_EN
//     When defined, a misaligned load or store is refused without issuing an
//     MMU request and is reported through resp_misalign_o. A half at an odd
//     offset, or a word at a nonzero offset, counts as misaligned.
//     When undefined, resp_misalign_o is tied low. The low address bits then
//     only select byte lanes.
//
// Ports:
//   clk_i, rst_i                  clock; synchronous active-high reset
//   req_valid_i / req_ready_o     request handshake; ready is high in IDLE only
//   req_rd_i, req_wr_i            load / store (neither means a cache op)
//   req_flush_i, req_invalidate_i, req_writeback_i   cache-op kind
//   req_addr_i, req_data_i        byte address, right-aligned store data
//   req_size_i, req_signed_i      0=byte 1=half 2/3=word, sign-extend loads
//   req_rd_idx_i                  destination tag, echoed on the response
//   resp_*                        one-cycle response pulse plus status bits
//   mmu_addr_o .. mmu_writeback_o request held to the MMU while BUSY
//   mmu_value_i, mmu_valid_i      read word and completion from the MMU
//   mmu_load_fault_i, mmu_store_fault_i   page faults from the MMU

module mmu_lsu_req_hold #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_rd_i,
  input  logic        req_wr_i,
  input  logic        req_flush_i,
  input  logic        req_invalidate_i,
  input  logic        req_writeback_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [4:0]  req_rd_idx_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_idx_o,
  output logic [31:0] resp_addr_o,
  output logic        resp_load_fault_o,
  output logic        resp_store_fault_o,
  output logic        resp_misalign_o,
  output logic        resp_bus_err_o,
  output logic [31:0] mmu_addr_o,
  output logic [31:0] mmu_data_o,
  output logic [3:0]  mmu_mask_o,
  output logic        mmu_rd_o,
  output logic        mmu_wr_o,
  output logic        mmu_flush_o,
  output logic        mmu_invalidate_o,
  output logic        mmu_writeback_o,
  input  logic [31:0] mmu_value_i,
  input  logic        mmu_valid_i,
  input  logic        mmu_load_fault_i,
  input  logic        mmu_store_fault_i
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // The counter only has to reach TIMEOUT_CYCLES-1 before the request is
  // aborted, so it never needs to represent TIMEOUT_CYCLES itself.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [0:0]    state_q;
  logic [CW-1:0] count_q;

  logic          op_rd_q, op_wr_q, op_flush_q, op_inv_q, op_wb_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [4:0]    idx_q;

  logic          resp_valid_q;
  logic [31:0]   resp_data_q;
  logic [4:0]    resp_idx_q;
  logic [31:0]   resp_addr_q;
  logic          resp_lf_q, resp_sf_q, resp_be_q;

  logic          busy;
  logic [1:0]    off;
  logic          is_byte, is_half;
  logic [31:0]   store_data;
  logic [3:0]    store_mask;
  logic [31:0]   load_shifted;
  logic [15:0]   load_half;
  logic [31:0]   load_data;
  logic          fault_in;
  logic          timeout_hit;

  assign busy    = (state_q == ST_BUSY);
  assign off     = addr_q[1:0];
  assign is_byte = (size_q == 2'd0);
  assign is_half = (size_q == 2'd1);

  // Store lane placement. A half always lands on an aligned half-word lane
  // pair, so a half at offset 3 still uses lanes 2-3.
  always_comb begin
    store_data = data_q;
    store_mask = 4'hF;
    if (is_byte) begin
      store_data = {4{data_q[7:0]}};
      store_mask = 4'b0001 << off;
    end else if (is_half) begin
      store_data = {2{data_q[15:0]}};
      store_mask = 4'b0011 << {off[1], 1'b0};
    end
  end

  // Load extraction. Bytes come from the addressed lane. Halves use the same
  // lane pair as stores.
  always_comb begin
    load_shifted = mmu_value_i >> {off, 3'b000};
    load_half    = off[1] ? mmu_value_i[31:16] : mmu_value_i[15:0];
    load_data    = load_shifted;
    if (is_byte) begin
      load_data = {{24{signed_q & load_shifted[7]}}, load_shifted[7:0]};
    end else if (is_half) begin
      load_data = {{16{signed_q & load_half[15]}}, load_half};
    end
  end

  assign fault_in    = mmu_load_fault_i | mmu_store_fault_i;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (count_q == LAST_COUNT);

`ifdef MMU_LSU_MISALIGN_CHECK_EN
  logic req_misaligned;
  logic resp_mis_q;
  assign req_misaligned = (req_rd_i | req_wr_i) &&
                          (((req_size_i == 2'd1) && req_addr_i[0]) ||
                           (req_size_i[1] && (req_addr_i[1:0] != 2'b00)));
`endif

  // Main control. Response fields are cleared every cycle so that they only
  // carry meaning during the resp_valid_o pulse. Every exit from BUSY returns
  // to IDLE in the same cycle that the response is presented, so the next
  // request can be accepted alongside it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      op_rd_q      <= 1'b0;
      op_wr_q      <= 1'b0;
      op_flush_q   <= 1'b0;
      op_inv_q     <= 1'b0;
      op_wb_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_idx_q   <= '0;
      resp_addr_q  <= '0;
      resp_lf_q    <= 1'b0;
      resp_sf_q    <= 1'b0;
      resp_be_q    <= 1'b0;
`ifdef MMU_LSU_MISALIGN_CHECK_EN
      resp_mis_q   <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_idx_q   <= '0;
      resp_addr_q  <= '0;
      resp_lf_q    <= 1'b0;
      resp_sf_q    <= 1'b0;
      resp_be_q    <= 1'b0;
`ifdef MMU_LSU_MISALIGN_CHECK_EN
      resp_mis_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_rd_q    <= req_rd_i;
            op_wr_q    <= req_wr_i;
            op_flush_q <= req_flush_i;
            op_inv_q   <= req_invalidate_i;
            op_wb_q    <= req_writeback_i;
            addr_q     <= req_addr_i;
            data_q     <= req_data_i;
            size_q     <= req_size_i;
            signed_q   <= req_signed_i;
            idx_q      <= req_rd_idx_i;
            count_q    <= '0;
`ifdef MMU_LSU_MISALIGN_CHECK_EN
            // Refused accesses answer directly and never reach the MMU.
            if (req_misaligned) begin
              resp_valid_q <= 1'b1;
              resp_mis_q   <= 1'b1;
              resp_idx_q   <= req_rd_idx_i;
              resp_addr_q  <= req_addr_i;
            end else begin
              state_q <= ST_BUSY;
            end
`else
            state_q <= ST_BUSY;
`endif
          end
        end
        default: begin
          count_q <= count_q + 1'b1;
          // A fault takes priority over a completion seen in the same cycle.
          if (fault_in) begin
            resp_valid_q <= 1'b1;
            resp_lf_q    <= mmu_load_fault_i;
            resp_sf_q    <= mmu_store_fault_i;
            resp_idx_q   <= idx_q;
            resp_addr_q  <= addr_q;
            state_q      <= ST_IDLE;
          end else if (mmu_valid_i) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= op_rd_q ? load_data : 32'h0;
            resp_idx_q   <= idx_q;
            resp_addr_q  <= addr_q;
            state_q      <= ST_IDLE;
          end else if (timeout_hit) begin
            resp_valid_q <= 1'b1;
            resp_be_q    <= 1'b1;
            resp_idx_q   <= idx_q;
            resp_addr_q  <= addr_q;
            state_q      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready_o        = ~busy;
  assign resp_valid_o       = resp_valid_q;
  assign resp_data_o        = resp_data_q;
  assign resp_rd_idx_o      = resp_idx_q;
  assign resp_addr_o        = resp_addr_q;
  assign resp_load_fault_o  = resp_lf_q;
  assign resp_store_fault_o = resp_sf_q;
  assign resp_bus_err_o     = resp_be_q;
`ifdef MMU_LSU_MISALIGN_CHECK_EN
  assign resp_misalign_o    = resp_mis_q;
`else
  assign resp_misalign_o    = 1'b0;
`endif

  // The MMU port is quiet outside BUSY.
  assign mmu_addr_o       = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mmu_data_o       = (busy && op_wr_q) ? store_data : 32'h0;
  assign mmu_mask_o       = busy ? (op_wr_q ? store_mask : 4'hF) : 4'h0;
  assign mmu_rd_o         = busy & op_rd_q;
  assign mmu_wr_o         = busy & op_wr_q;
  assign mmu_flush_o      = busy & op_flush_q;
  assign mmu_invalidate_o = busy & op_inv_q;
  assign mmu_writeback_o  = busy & op_wb_q;

endmodule

// File: tb/tb_mmu_lsu_req_hold.sv
// tb_mmu_lsu_req_hold
//
// Purpose:
//   Self-checking bench for mmu_lsu_req_hold. The DUT is built with
//   TIMEOUT_CYCLES=4 so that the watchdog path can be exercised quickly.
//   Expected responses are pushed onto a queue when a request is driven and
//   popped when the DUT responds.
//   Inputs are driven, and outputs sampled, on the falling clock edge.

module tb_mmu_lsu_req_hold;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_rd_i, req_wr_i;
  logic        req_flush_i, req_invalidate_i, req_writeback_i;
  logic [31:0] req_addr_i, req_data_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [4:0]  req_rd_idx_i;
  logic        req_ready_o, resp_valid_o;
  logic [31:0] resp_data_o, resp_addr_o;
  logic [4:0]  resp_rd_idx_o;
  logic        resp_load_fault_o, resp_store_fault_o, resp_misalign_o, resp_bus_err_o;
  logic [31:0] mmu_addr_o, mmu_data_o;
  logic [3:0]  mmu_mask_o;
  logic        mmu_rd_o, mmu_wr_o, mmu_flush_o, mmu_invalidate_o, mmu_writeback_o;
  logic [31:0] mmu_value_i;
  logic        mmu_valid_i, mmu_load_fault_i, mmu_store_fault_i;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic [31:0] addr;
    logic        lf;
    logic        sf;
    logic        mis;
    logic        be;
  } resp_t;

  resp_t exp_q[$];
  resp_t exp_r, got_r;
  int    checks = 0;
  int    errors = 0;

  always #5 clk_i = ~clk_i;

  mmu_lsu_req_hold #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_rd_i(req_rd_i), .req_wr_i(req_wr_i),
    .req_flush_i(req_flush_i), .req_invalidate_i(req_invalidate_i),
    .req_writeback_i(req_writeback_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_size_i(req_size_i), .req_signed_i(req_signed_i),
    .req_rd_idx_i(req_rd_idx_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .resp_rd_idx_o(resp_rd_idx_o), .resp_addr_o(resp_addr_o),
    .resp_load_fault_o(resp_load_fault_o), .resp_store_fault_o(resp_store_fault_o),
    .resp_misalign_o(resp_misalign_o), .resp_bus_err_o(resp_bus_err_o),
    .mmu_addr_o(mmu_addr_o), .mmu_data_o(mmu_data_o), .mmu_mask_o(mmu_mask_o),
    .mmu_rd_o(mmu_rd_o), .mmu_wr_o(mmu_wr_o), .mmu_flush_o(mmu_flush_o),
    .mmu_invalidate_o(mmu_invalidate_o), .mmu_writeback_o(mmu_writeback_o),
    .mmu_value_i(mmu_value_i), .mmu_valid_i(mmu_valid_i),
    .mmu_load_fault_i(mmu_load_fault_i), .mmu_store_fault_i(mmu_store_fault_i)
  );

  // Drives a request for one cycle. It is called just after a falling edge and
  // returns at the next falling edge, which is the first BUSY cycle.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] size, input logic sgn, input logic [4:0] idx);
    req_valid_i = 1'b1; req_rd_i = rd; req_wr_i = wr;
    {req_flush_i, req_invalidate_i, req_writeback_i} = op;
    req_addr_i = addr; req_data_i = data; req_size_i = size;
    req_signed_i = sgn; req_rd_idx_i = idx;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_rd_i = 1'b0; req_wr_i = 1'b0;
    {req_flush_i, req_invalidate_i, req_writeback_i} = 3'b000;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = 0; req_rd_i = 0; req_wr_i = 0; req_flush_i = 0;
    req_invalidate_i = 0; req_writeback_i = 0; req_addr_i = 0; req_data_i = 0;
    req_size_i = 0; req_signed_i = 0; req_rd_idx_i = 0;
    mmu_value_i = 0; mmu_valid_i = 0; mmu_load_fault_i = 0; mmu_store_fault_i = 0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready_o); end
    checks++;
    if (resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid_o); end
    checks++;
    if ({mmu_rd_o, mmu_wr_o, mmu_flush_o, mmu_invalidate_o, mmu_writeback_o} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_mmu_ops: got %b expected 00000",
        {mmu_rd_o, mmu_wr_o, mmu_flush_o, mmu_invalidate_o, mmu_writeback_o});
    end
    checks++;
    if ({mmu_addr_o, mmu_mask_o, resp_data_o} !== 68'h0) begin
      errors++; $display("[TB] FAIL reset_buses: got addr %h mask %h data %h expected all 0",
        mmu_addr_o, mmu_mask_o, resp_data_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Word load that completes after three cycles of holding mmu_rd_o.
  task automatic test_load_word();
    exp_q.push_back('{data: 32'hDEADBEEF, idx: 5'd7, addr: 32'h8000_0004, lf: 0, sf: 0, mis: 0, be: 0});
    issue(1, 0, 3'b000, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 5'd7);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({mmu_rd_o, req_ready_o, resp_valid_o} !== 3'b100) begin
        errors++; $display("[TB] FAIL load_word_hold c%0d: got rd/ready/resp %b expected 100", c,
          {mmu_rd_o, req_ready_o, resp_valid_o});
      end
      if (c == 3) begin mmu_valid_i = 1'b1; mmu_value_i = 32'hDEADBEEF; end
      @(negedge clk_i);
    end
    mmu_valid_i = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL load_word_resp_valid: got %b expected 1", resp_valid_o);
    end
    exp_r = exp_q.pop_front();
    got_r = {resp_data_o, resp_rd_idx_o, resp_addr_o, resp_load_fault_o, resp_store_fault_o, resp_misalign_o, resp_bus_err_o};
    checks++;
    if (got_r !== exp_r) begin errors++; $display("[TB] FAIL load_word_resp: got %h expected %h", got_r, exp_r); end
    checks++;
    if ({mmu_rd_o, req_ready_o} !== 2'b01) begin
      errors++; $display("[TB] FAIL load_word_release: got rd/ready %b expected 01", {mmu_rd_o, req_ready_o});
    end
  endtask

  // Minimum-latency sub-word loads with zero and sign extension.
  task automatic test_load_extend();
    logic [31:0] addrs [4] = '{32'h0000_1001, 32'h0000_1001, 32'h0000_2002, 32'h0000_2002};
    logic [31:0] vals  [4] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000, 32'h8001_0000};
    logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        sgns  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] expd  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{data: expd[i], idx: 5'(i + 1), addr: addrs[i], lf: 0, sf: 0, mis: 0, be: 0});
      issue(1, 0, 3'b000, addrs[i], 32'h0, sizes[i], sgns[i], 5'(i + 1));
      checks++;
      if (mmu_mask_o !== 4'hF) begin errors++; $display("[TB] FAIL load_ext_mask%0d: got %h expected f", i, mmu_mask_o); end
      mmu_valid_i = 1'b1; mmu_value_i = vals[i];
      @(negedge clk_i);
      mmu_valid_i = 1'b0;
      exp_r = exp_q.pop_front();
      got_r = {resp_data_o, resp_rd_idx_o, resp_addr_o, resp_load_fault_o, resp_store_fault_o, resp_misalign_o, resp_bus_err_o};
      checks++;
      if (resp_valid_o !== 1'b1 || got_r !== exp_r) begin
        errors++; $display("[TB] FAIL load_ext%0d: got valid %b resp %h expected valid 1 resp %h", i, resp_valid_o, got_r, exp_r);
      end
    end
  endtask

  // Sub-word stores: lane replication and byte enables held until valid.
  task automatic test_store_lanes();
    logic [31:0] addrs [2] = '{32'h0000_3002, 32'h0000_3003};
    logic [31:0] datas [2] = '{32'h0000_1234, 32'h0000_00AB};
    logic [1:0]  sizes [2] = '{2'd1, 2'd0};
    logic [31:0] expd  [2] = '{32'h1234_1234, 32'hABAB_ABAB};
    logic [3:0]  expm  [2] = '{4'b1100, 4'b1000};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{data: 32'h0, idx: 5'd20, addr: addrs[i], lf: 0, sf: 0, mis: 0, be: 0});
      issue(0, 1, 3'b000, addrs[i], datas[i], sizes[i], 1'b0, 5'd20);
      for (int c = 1; c <= 2; c++) begin
        checks++;
        if ({mmu_data_o, mmu_mask_o, mmu_wr_o, mmu_rd_o} !== {expd[i], expm[i], 2'b10}) begin
          errors++; $display("[TB] FAIL store_lanes%0d c%0d: got data %h mask %b wr %b rd %b expected %h %b 1 0",
            i, c, mmu_data_o, mmu_mask_o, mmu_wr_o, mmu_rd_o, expd[i], expm[i]);
        end
        checks++;
        if (mmu_addr_o !== {addrs[i][31:2], 2'b00}) begin
          errors++; $display("[TB] FAIL store_addr%0d: got %h expected %h", i, mmu_addr_o, {addrs[i][31:2], 2'b00});
        end
        if (c == 2) begin mmu_valid_i = 1'b1; mmu_value_i = 32'hFFFF_FFFF; end
        @(negedge clk_i);
      end
      mmu_valid_i = 1'b0;
      exp_r = exp_q.pop_front();
      got_r = {resp_data_o, resp_rd_idx_o, resp_addr_o, resp_load_fault_o, resp_store_fault_o, resp_misalign_o, resp_bus_err_o};
      checks++;
      if (resp_valid_o !== 1'b1 || got_r !== exp_r || mmu_wr_o !== 1'b0) begin
        errors++; $display("[TB] FAIL store_resp%0d: got valid %b wr %b resp %h expected valid 1 wr 0 resp %h",
          i, resp_valid_o, mmu_wr_o, got_r, exp_r);
      end
    end
  endtask

  // Faults: a store fault together with valid, and a load fault on its own.
  task automatic test_faults();
    exp_q.push_back('{data: 32'h0, idx: 5'd0, addr: 32'h4000_0010, lf: 0, sf: 1, mis: 0, be: 0});
    issue(0, 1, 3'b000, 32'h4000_0010, 32'hCAFE_F00D, 2'd2, 1'b0, 5'd0);
    checks++;
    if ({mmu_data_o, mmu_mask_o} !== {32'hCAFE_F00D, 4'hF}) begin
      errors++; $display("[TB] FAIL store_word_bus: got %h %h expected cafef00d f", mmu_data_o, mmu_mask_o);
    end
    mmu_valid_i = 1'b1; mmu_store_fault_i = 1'b1; mmu_value_i = 32'h1234_5678;
    @(negedge clk_i);
    mmu_valid_i = 1'b0; mmu_store_fault_i = 1'b0;
    exp_r = exp_q.pop_front();
    got_r = {resp_data_o, resp_rd_idx_o, resp_addr_o, resp_load_fault_o, resp_store_fault_o, resp_misalign_o, resp_bus_err_o};
    checks++;
    if (resp_valid_o !== 1'b1 || got_r !== exp_r) begin
      errors++; $display("[TB] FAIL store_fault: got valid %b resp %h expected valid 1 resp %h", resp_valid_o, got_r, exp_r);
    end

    exp_q.push_back('{data: 32'h0, idx: 5'd12, addr: 32'h9000_0001, lf: 1, sf: 0, mis: 0, be: 0});
    issue(1, 0, 3'b000, 32'h9000_0001, 32'h0, 2'd0, 1'b0, 5'd12);
    mmu_load_fault_i = 1'b1; mmu_value_i = 32'h5555_5555;
    @(negedge clk_i);
    mmu_load_fault_i = 1'b0;
    exp_r = exp_q.pop_front();
    got_r = {resp_data_o, resp_rd_idx_o, resp_addr_o, resp_load_fault_o, resp_store_fault_o, resp_misalign_o, resp_bus_err_o};
    checks++;
    if (resp_valid_o !== 1'b1 || got_r !== exp_r) begin
      errors++; $display("[TB] FAIL load_fault: got valid %b resp %h expected valid 1 resp %h", resp_valid_o, got_r, exp_r);
    end
  endtask

  // Watchdog abort on cycle 5, then a new request accepted in that same cycle.
  task automatic test_timeout_back_to_back();
    exp_q.push_back('{data: 32'h0, idx: 5'd9, addr: 32'h5000_0008, lf: 0, sf: 0, mis: 0, be: 1});
    issue(1, 0, 3'b000, 32'h5000_0008, 32'h0, 2'd2, 1'b0, 5'd9);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({resp_valid_o, mmu_rd_o} !== 2'b01) begin
        errors++; $display("[TB] FAIL timeout_wait c%0d: got resp/rd %b expected 01", c, {resp_valid_o, mmu_rd_o});
      end
      @(negedge clk_i);
    end
    exp_r = exp_q.pop_front();
    got_r = {resp_data_o, resp_rd_idx_o, resp_addr_o, resp_load_fault_o, resp_store_fault_o, resp_misalign_o, resp_bus_err_o};
    checks++;
    if (resp_valid_o !== 1'b1 || got_r !== exp_r || req_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_resp: got valid %b ready %b resp %h expected valid 1 ready 1 resp %h",
        resp_valid_o, req_ready_o, got_r, exp_r);
    end
    exp_q.push_back('{data: 32'h1122_3344, idx: 5'd10, addr: 32'h6000_0000, lf: 0, sf: 0, mis: 0, be: 0});
    issue(1, 0, 3'b000, 32'h6000_0000, 32'h0, 2'd2, 1'b0, 5'd10);
    checks++;
    if ({mmu_rd_o, mmu_addr_o} !== {1'b1, 32'h6000_0000}) begin
      errors++; $display("[TB] FAIL back_to_back_accept: got rd %b addr %h expected 1 60000000", mmu_rd_o, mmu_addr_o);
    end
    mmu_valid_i = 1'b1; mmu_value_i = 32'h1122_3344;
    @(negedge clk_i);
    mmu_valid_i = 1'b0;
    exp_r = exp_q.pop_front();
    got_r = {resp_data_o, resp_rd_idx_o, resp_addr_o, resp_load_fault_o, resp_store_fault_o, resp_misalign_o, resp_bus_err_o};
    checks++;
    if (resp_valid_o !== 1'b1 || got_r !== exp_r) begin
      errors++; $display("[TB] FAIL back_to_back_resp: got valid %b resp %h expected valid 1 resp %h", resp_valid_o, got_r, exp_r);
    end
  endtask

  // Cache op held on its own strobe, plus a store attempt ignored while BUSY.
  task automatic test_cache_op_busy_ignore();
    exp_q.push_back('{data: 32'h0, idx: 5'd4, addr: 32'h8000_0040, lf: 0, sf: 0, mis: 0, be: 0});
    issue(0, 0, 3'b100, 32'h8000_0040, 32'h0, 2'd2, 1'b0, 5'd4);
    req_valid_i = 1'b1; req_wr_i = 1'b1; req_addr_i = 32'h0BAD_0000; req_rd_idx_i = 5'd31;
    checks++;
    if ({mmu_flush_o, mmu_invalidate_o, mmu_writeback_o, mmu_rd_o, mmu_wr_o} !== 5'b10000) begin
      errors++; $display("[TB] FAIL cache_op_strobes: got %b expected 10000",
        {mmu_flush_o, mmu_invalidate_o, mmu_writeback_o, mmu_rd_o, mmu_wr_o});
    end
    @(negedge clk_i);
    req_valid_i = 1'b0; req_wr_i = 1'b0;
    checks++;
    if ({mmu_addr_o, mmu_wr_o, mmu_flush_o} !== {32'h8000_0040, 2'b01}) begin
      errors++; $display("[TB] FAIL busy_ignore: got addr %h wr %b flush %b expected 80000040 0 1", mmu_addr_o, mmu_wr_o, mmu_flush_o);
    end
    mmu_valid_i = 1'b1; mmu_value_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    mmu_valid_i = 1'b0;
    exp_r = exp_q.pop_front();
    got_r = {resp_data_o, resp_rd_idx_o, resp_addr_o, resp_load_fault_o, resp_store_fault_o, resp_misalign_o, resp_bus_err_o};
    checks++;
    if (resp_valid_o !== 1'b1 || got_r !== exp_r) begin
      errors++; $display("[TB] FAIL cache_op_resp: got valid %b resp %h expected valid 1 resp %h", resp_valid_o, got_r, exp_r);
    end
  endtask

  // A reset in the middle of BUSY drops the request without any response.
  task automatic test_reset_mid_busy();
    issue(1, 0, 3'b000, 32'h7000_0000, 32'h0, 2'd2, 1'b0, 5'd2);
    rst_i = 1'b1; mmu_valid_i = 1'b1; mmu_value_i = 32'h0000_00AA;
    @(negedge clk_i);
    rst_i = 1'b0; mmu_valid_i = 1'b0;
    checks++;
    if ({mmu_rd_o, req_ready_o, resp_valid_o} !== 3'b010) begin
      errors++; $display("[TB] FAIL reset_mid_busy: got rd/ready/resp %b expected 010", {mmu_rd_o, req_ready_o, resp_valid_o});
    end
    @(negedge clk_i);
    checks++;
    if (resp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_resp: got %b expected 0", resp_valid_o); end
  endtask

`ifdef MMU_LSU_MISALIGN_CHECK_EN
  // Misaligned accesses answer one cycle after acceptance and never reach the MMU.
  task automatic test_misalign();
    logic [31:0] addrs [2] = '{32'h7000_0002, 32'h7000_0101};
    logic        rds   [2] = '{1'b1, 1'b0};
    logic [1:0]  sizes [2] = '{2'd2, 2'd1};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{data: 32'h0, idx: 5'd3, addr: addrs[i], lf: 0, sf: 0, mis: 1, be: 0});
      issue(rds[i], ~rds[i], 3'b000, addrs[i], 32'hFFFF, sizes[i], 1'b0, 5'd3);
      exp_r = exp_q.pop_front();
      got_r = {resp_data_o, resp_rd_idx_o, resp_addr_o, resp_load_fault_o, resp_store_fault_o, resp_misalign_o, resp_bus_err_o};
      checks++;
      if (resp_valid_o !== 1'b1 || got_r !== exp_r) begin
        errors++; $display("[TB] FAIL misalign_resp%0d: got valid %b resp %h expected valid 1 resp %h", i, resp_valid_o, got_r, exp_r);
      end
      checks++;
      if ({mmu_rd_o, mmu_wr_o, req_ready_o} !== 3'b001) begin
        errors++; $display("[TB] FAIL misalign_no_mmu%0d: got rd/wr/ready %b expected 001", i, {mmu_rd_o, mmu_wr_o, req_ready_o});
      end
      @(negedge clk_i);
      checks++;
      if ({mmu_rd_o, mmu_wr_o, resp_valid_o} !== 3'b000) begin
        errors++; $display("[TB] FAIL misalign_quiet%0d: got rd/wr/resp %b expected 000", i, {mmu_rd_o, mmu_wr_o, resp_valid_o});
      end
    end
  endtask
`endif

  // Global guard so the run ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    @(negedge clk_i);
    test_reset();
    test_load_word();
    test_load_extend();
    test_store_lanes();
    test_faults();
    test_timeout_back_to_back();
    test_cache_op_busy_ignore();
    test_reset_mid_busy();
`ifdef MMU_LSU_MISALIGN_CHECK_EN
    test_misalign();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
